// File: rtl/clk_div_monitor.sv
// Reference-domain monitor for the programmable clock divider.
// It measures the divided clock's period and high time, flags bad periods, and reports lock.
module clk_div_monitor #(
  parameter int RATIO_WIDTH = 8,
  parameter int LOCK_CNT    = 4
) (
  input  logic                   I_ref_clk,
  input  logic                   I_rst,
  input  logic                   I_clk_en,
  input  logic [RATIO_WIDTH-1:0] I_div_ratio,
  input  logic                   I_div_clk,
  output logic [RATIO_WIDTH:0]   O_period,
  output logic [RATIO_WIDTH-1:0] O_high_cnt,
  output logic                   O_meas_valid,
  output logic                   O_err,
  output logic                   O_lock
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  localparam logic [RATIO_WIDTH:0]   P_ONE    = {{RATIO_WIDTH{1'b0}}, 1'b1};
  localparam logic [RATIO_WIDTH:0]   P_MAX    = {(RATIO_WIDTH+1){1'b1}};
  localparam logic [RATIO_WIDTH-1:0] H_ONE    = {{(RATIO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RATIO_WIDTH-1:0] H_MAX    = {RATIO_WIDTH{1'b1}};
  localparam logic [RATIO_WIDTH-1:0] R_TWO    = {{(RATIO_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [3:0]             LOCK_TGT = 4'(LOCK_CNT);

  logic [1:0]             state_q, state_d;
  logic                   d_q;
  logic [RATIO_WIDTH:0]   cfg_q;
  logic [RATIO_WIDTH:0]   period_cnt_q, period_cnt_d;
  logic [RATIO_WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [3:0]             lock_cnt_q, lock_cnt_d;
  logic [RATIO_WIDTH:0]   period_q, period_d;
  logic [RATIO_WIDTH-1:0] high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   lock_q, lock_d;

  logic [RATIO_WIDTH:0]   cfg_s;
  logic [RATIO_WIDTH:0]   ratio_ext_s;
  logic [RATIO_WIDTH:0]   high_ext_s;
  logic [RATIO_WIDTH:0]   limit_s;
  logic [RATIO_WIDTH:0]   p_inc_s;
  logic [RATIO_WIDTH-1:0] h_inc_s;
  logic [3:0]             lock_next_s;
  logic                   bypass_s;
  logic                   rise_s;
  logic                   good_s;

  assign cfg_s       = {I_clk_en, I_div_ratio};
  assign bypass_s    = ~I_clk_en | (I_div_ratio < R_TWO);
  assign rise_s      = I_div_clk & ~d_q;
  assign ratio_ext_s = {1'b0, I_div_ratio};
  assign high_ext_s  = {1'b0, high_cnt_q};
  assign limit_s     = {I_div_ratio, 1'b0};
  // Counters saturate so a stuck divider cannot wrap back into a plausible count.
  assign p_inc_s     = (period_cnt_q == P_MAX) ? period_cnt_q : period_cnt_q + P_ONE;
  assign h_inc_s     = (high_cnt_q == H_MAX) ? high_cnt_q : high_cnt_q + H_ONE;
  assign lock_next_s = (lock_cnt_q < LOCK_TGT) ? lock_cnt_q + 4'd1 : lock_cnt_q;
  assign good_s      = (period_cnt_q == ratio_ext_s) &&
                       ((high_ext_s == (ratio_ext_s >> 1)) ||
                        (high_ext_s == ((ratio_ext_s + P_ONE) >> 1)));

  // Next-state logic: bypass and config change take priority over measurement events.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    lock_d       = lock_q;
    if (bypass_s || (cfg_s != cfg_q)) begin
      state_d      = bypass_s ? ST_IDLE : ST_SYNC;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      lock_cnt_d   = 4'd0;
      lock_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          if (rise_s) begin
            period_cnt_d = P_ONE;
            high_cnt_d   = H_ONE;
            state_d      = ST_MEAS;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_MEAS: begin
          if (rise_s) begin
            period_d     = period_cnt_q;
            high_d       = high_cnt_q;
            valid_d      = 1'b1;
            period_cnt_d = P_ONE;
            high_cnt_d   = H_ONE;
            if (good_s) begin
              lock_cnt_d = lock_next_s;
              lock_d     = (lock_next_s == LOCK_TGT) ? 1'b1 : lock_q;
            end else begin
              err_d      = 1'b1;
              lock_cnt_d = 4'd0;
              lock_d     = 1'b0;
            end
          end else if (period_cnt_q >= limit_s) begin
            err_d      = 1'b1;
            lock_cnt_d = 4'd0;
            lock_d     = 1'b0;
            state_d    = ST_SYNC;
          end else begin
            period_cnt_d = p_inc_s;
            high_cnt_d   = I_div_clk ? h_inc_s : high_cnt_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge I_ref_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q      <= ST_IDLE;
      d_q          <= 1'b0;
      cfg_q        <= '0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      lock_cnt_q   <= 4'd0;
      period_q     <= '0;
      high_q       <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      d_q          <= I_div_clk;
      cfg_q        <= cfg_s;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      lock_q       <= lock_d;
    end
  end

  assign O_period     = period_q;
  assign O_high_cnt   = high_q;
  assign O_meas_valid = valid_q;
  assign O_err        = err_q;
  assign O_lock       = lock_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized bench for clk_div_monitor; the reference model works from rise timestamps and a
// sample history instead of running counters.
module tb_clk_div_monitor;
  localparam int RW   = 8;
  localparam int LK   = 4;
  localparam int MASK = 16383;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [RW-1:0] ratio;
  logic          div;
  logic [RW:0]   O_period;
  logic [RW-1:0] O_high_cnt;
  logic          O_meas_valid, O_err, O_lock;

  clk_div_monitor #(.RATIO_WIDTH(RW), .LOCK_CNT(LK)) dut (
    .I_ref_clk(clk), .I_rst(rst), .I_clk_en(en), .I_div_ratio(ratio), .I_div_clk(div),
    .O_period(O_period), .O_high_cnt(O_high_cnt), .O_meas_valid(O_meas_valid),
    .O_err(O_err), .O_lock(O_lock)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state.
  int       t = 0;
  bit       samp [16384];
  int       m_mode;      // 0 bypass/idle, 1 waiting for first rise, 2 measuring
  int       m_s;         // cycle index of the rise that opened the current period
  int       m_streak;
  bit [8:0] m_prev_cfg;
  bit       m_prev_div;
  int       e_period, e_high;
  bit       e_valid, e_err, e_lock;

  int n_err = 0, n_valid = 0, last_err_period = 0;

  task automatic model_reset();
    m_mode = 0; m_s = 0; m_streak = 0; m_prev_cfg = '0; m_prev_div = 1'b0;
    e_period = 0; e_high = 0; e_valid = 1'b0; e_err = 1'b0; e_lock = 1'b0;
  endtask

  task automatic model_edge();
    bit [8:0] cfg;
    bit       byp, rise, good;
    int       r, per, hi;
    r    = int'(ratio);
    cfg  = {en, ratio};
    byp  = !en || (r < 2);
    rise = div && !m_prev_div;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (byp) begin
      m_mode = 0; m_streak = 0; e_lock = 1'b0;
    end else if (cfg != m_prev_cfg) begin
      m_mode = 1; m_streak = 0; e_lock = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (rise) begin
        m_mode = 2; m_s = t;
      end
    end else if (rise) begin
      per = t - m_s;
      hi  = 0;
      for (int i = m_s; i < t; i++) hi += int'(samp[i & MASK]);
      if (hi > 255) hi = 255;
      e_period = per; e_high = hi; e_valid = 1'b1;
      good = (per == r) && ((hi == r / 2) || (hi == (r + 1) / 2));
      if (good) begin
        if (m_streak < LK) m_streak++;
        if (m_streak == LK) e_lock = 1'b1;
      end else begin
        e_err = 1'b1; m_streak = 0; e_lock = 1'b0;
      end
      m_s = t;
    end else if (t - m_s >= 2 * r) begin
      e_err = 1'b1; m_streak = 0; e_lock = 1'b0; m_mode = 1;
    end
    samp[t & MASK] = div;
    m_prev_div = div;
    m_prev_cfg = cfg;
    t++;
  endtask

  task automatic check_outputs();
    chk("period", 32'(O_period), e_period);
    chk("high",   32'(O_high_cnt), e_high);
    chk("valid",  32'(O_meas_valid), 32'(e_valid));
    chk("err",    32'(O_err), 32'(e_err));
    chk("lock",   32'(O_lock), 32'(e_lock));
  endtask

  task automatic step(input bit d);
    div = d;
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
    if (O_err) begin
      n_err++;
      last_err_period = int'(O_period);
    end
    if (O_meas_valid) n_valid++;
  endtask

  // Ideal divider: n whole periods of length per, high for the first hi samples of each.
  task automatic run(input int n, input int per, input int hi);
    for (int p = 0; p < n; p++)
      for (int k = 0; k < per; k++) step(k < hi);
  endtask

  int e0, v0, r, per, hi, kind;
  bit b;

  initial begin
    rst = 1'b1; en = 1'b0; ratio = 8'd0; div = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(posedge clk); #1; rst = 1'b0;

    en = 1'b0; ratio = 8'd1;
    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)));
    chk("byp_valid", n_valid, 0);
    chk("byp_err", n_err, 0);
    chk("byp_lock", 32'(O_lock), 0);

    en = 1'b1; ratio = 8'd4;
    run(8, 4, 2);
    chk("r4_lock", 32'(O_lock), 1);
    chk("r4_period", 32'(O_period), 4);
    chk("r4_high", 32'(O_high_cnt), 2);
    chk("r4_noerr", n_err, 0);

    ratio = 8'd5;
    run(6, 5, 2);
    run(3, 5, 3);
    chk("r5_lock", 32'(O_lock), 1);
    chk("r5_period", 32'(O_period), 5);

    e0 = n_err;
    ratio = 8'd6;
    step(1'b1);
    chk("r6_lockdrop", 32'(O_lock), 0);
    for (int k = 1; k < 6; k++) step(k < 3);
    run(7, 6, 3);
    chk("r6_lock", 32'(O_lock), 1);
    chk("r6_period", 32'(O_period), 6);
    chk("r6_high", 32'(O_high_cnt), 3);
    chk("r6_noerr", n_err - e0, 0);

    ratio = 8'd4;
    run(8, 4, 2);
    e0 = n_err;
    run(1, 5, 2);
    run(3, 4, 2);
    chk("glitch_errs", n_err - e0, 1);
    chk("glitch_period", last_err_period, 5);
    chk("glitch_unlock", 32'(O_lock), 0);
    run(3, 4, 2);
    chk("glitch_relock", 32'(O_lock), 1);

    ratio = 8'd3;
    run(8, 3, 1);
    chk("r3_lock", 32'(O_lock), 1);
    e0 = n_err; v0 = n_valid;
    repeat (12) step(1'b1);
    chk("stuck_errs", n_err - e0, 1);
    chk("stuck_valid", n_valid - v0, 1);
    chk("stuck_lock", 32'(O_lock), 0);

    ratio = 8'd6;
    run(6, 6, 3);
    step(1'b1); step(1'b1); step(1'b0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_period", 32'(O_period), 0);
    @(posedge clk); #1; rst = 1'b0;
    run(7, 6, 3);
    chk("rst_relock", 32'(O_lock), 1);

    for (int c = 0; c < 120; c++) begin
      r     = $urandom_range(0, 9);
      en    = ($urandom_range(0, 7) != 0);
      ratio = 8'(r);
      kind  = $urandom_range(0, 9);
      if (kind == 0) begin
        b = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 25)) step(b);
      end else begin
        per = r;
        if (kind == 1) per = r + 1;
        if (kind == 2) per = r - 1;
        if (per < 1) per = 1;
        hi = ($urandom_range(0, 1) != 0) ? per / 2 : (per + 1) / 2;
        run($urandom_range(1, 6), per, hi);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
